// File: rtl/dds_phase_gen.sv
// Dual DDS phase accumulator feeding the 12-bit sine LUT.
// Ports: sys_clk/sys_rst, tuning-word valid/ready handshake
// (tw_chan/tw_data/tw_sync), per-voice gate, sample strobe
// clk_ena and the two 12-bit LUT addresses.
module dds_phase_gen #(
  parameter int ACC_W = 32,
  parameter int DIV   = 2268,
  parameter int DIV_W = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tw_valid,
  output logic             tw_ready,
  input  logic             tw_chan,
  input  logic [ACC_W-1:0] tw_data,
  input  logic             tw_sync,
  input  logic [1:0]       gate,
  output logic             clk_ena,
  output logic [11:0]      dds1_oaddr,
  output logic [11:0]      dds2_oaddr
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             clk_ena_q, clk_ena_d;
  logic [ACC_W-1:0] acc1_q, acc1_d;
  logic [ACC_W-1:0] acc2_q, acc2_d;
  logic [ACC_W-1:0] tw1_q, tw1_d;
  logic [ACC_W-1:0] tw2_q, tw2_d;
  logic             pend_q, pend_d;
  logic             hchan_q, hchan_d;
  logic [ACC_W-1:0] hdata_q, hdata_d;
  logic             hsync_q, hsync_d;
  logic [11:0]      addr1_q, addr1_d;
  logic [11:0]      addr2_q, addr2_d;

  logic             tick;
  logic             xfer;
  logic             apply1, apply2;
  logic [ACC_W-1:0] eff1, eff2;

  always_comb begin
    tick = (count_q == DIV_W'(DIV - 1));
    xfer = tw_valid & ~pend_q;
    // A held update only takes effect on a tick edge.
    apply1 = pend_q & ~hchan_q;
    apply2 = pend_q & hchan_q;
    eff1 = apply1 ? hdata_q : tw1_q;
    eff2 = apply2 ? hdata_q : tw2_q;

    count_d   = tick ? '0 : count_q + 1'b1;
    clk_ena_d = tick;

    tw1_d   = tw1_q;
    tw2_d   = tw2_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;

    if (tick) begin
      tw1_d = eff1;
      tw2_d = eff2;

      if (!gate[0])
        acc1_d = '0;
      else if (apply1 && hsync_q)
        acc1_d = '0;
      else
        acc1_d = acc1_q + eff1;

      if (!gate[1])
        acc2_d = '0;
      else if (apply2 && hsync_q)
        acc2_d = '0;
      else
        acc2_d = acc2_q + eff2;

      addr1_d = acc1_d[ACC_W-1 -: 12];
      addr2_d = acc2_d[ACC_W-1 -: 12];
    end

    // A transfer on a tick edge sees pend_q low, so it
    // waits for the following tick.
    if (pend_q)
      pend_d = ~tick;
    else
      pend_d = xfer;

    hchan_d = xfer ? tw_chan : hchan_q;
    hdata_d = xfer ? tw_data : hdata_q;
    hsync_d = xfer ? tw_sync : hsync_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      count_q   <= '0;
      clk_ena_q <= 1'b0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      tw1_q     <= '0;
      tw2_q     <= '0;
      pend_q    <= 1'b0;
      hchan_q   <= 1'b0;
      hdata_q   <= '0;
      hsync_q   <= 1'b0;
      addr1_q   <= '0;
      addr2_q   <= '0;
    end else begin
      count_q   <= count_d;
      clk_ena_q <= clk_ena_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      tw1_q     <= tw1_d;
      tw2_q     <= tw2_d;
      pend_q    <= pend_d;
      hchan_q   <= hchan_d;
      hdata_q   <= hdata_d;
      hsync_q   <= hsync_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
    end
  end

  assign tw_ready   = ~pend_q;
  assign clk_ena    = clk_ena_q;
  assign dds1_oaddr = addr1_q;
  assign dds2_oaddr = addr2_q;

endmodule
